rr_lock_arbiter: RTL and testbench

//   Registered N-way arbiter; successor to our combinational fixed-priority arbiter.

---
 rtl/arbiter_pkg.sv | 13 +
 rtl/rr_priority_select.sv | 39 +++
 rtl/rr_lock_arbiter.sv | 111 +++++++++++
 tb/tb_rr_lock_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared arbitration modes and owner-state encoding for the registered lock arbiter.
// Pure definitions; no timing or backpressure of its own.
package arbiter_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational winner select: fixed priority (index 0 first) or round-robin from ptr.
// Zero latency; no backpressure, masked requesters simply never win.
module rr_priority_select
  import arbiter_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter int IDX_W  = $clog2(INPUTS)
) (
  input  logic [INPUTS-1:0] req,
  input  logic [INPUTS-1:0] mask,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [INPUTS-1:0] onehot,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [INPUTS-1:0]   eff;
  logic [2*INPUTS-1:0] dbl;

  assign eff = req & ~mask;
  assign dbl = {eff, eff};

  // Round-robin scans the doubled vector from ptr, so the upper copy provides the wrap.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int j = 0; j < 2*INPUTS; j++) begin
      if (!any && dbl[j] &&
          ((mode == MODE_RR) ? (j >= int'(ptr)) : (j < INPUTS))) begin
        any = 1'b1;
        idx = (j >= INPUTS) ? IDX_W'(j - INPUTS) : IDX_W'(j);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered N-way arbiter, fixed or round-robin, with owner lock bounded by MAX_HOLD; grant one cycle after req.
// No backpressure: a locked owner keeps the grant until it drops req/lock or hits the hold limit.
module rr_lock_arbiter
  import arbiter_pkg::*;
#(
  parameter int INPUTS   = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = $clog2(INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [INPUTS-1:0] req,
  input  logic [INPUTS-1:0] lock,
  output logic [INPUTS-1:0] grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [INPUTS-1:0] grant_nxt;
  logic [IDX_W-1:0]  idx_nxt;

  logic              locked, timeout, keep, regrant;
  logic [INPUTS-1:0] sel_mask, sel_onehot;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] w);
    return (w == IDX_W'(INPUTS - 1)) ? '0 : w + IDX_W'(1);
  endfunction

  assign locked   = (state == ST_OWNED) && req[grant_idx] && lock[grant_idx];
  assign timeout  = locked && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign keep     = locked && !timeout;
  // On timeout the owner sits out one arbitration so others get a turn.
  assign sel_mask = timeout ? grant : '0;
  assign regrant  = timeout && !sel_any;

  rr_priority_select #(
    .INPUTS (INPUTS),
    .IDX_W  (IDX_W)
  ) u_select (
    .req    (req),
    .mask   (sel_mask),
    .ptr    (ptr),
    .mode   (mode),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = sel_any ? ST_OWNED : ST_IDLE;
      ST_OWNED: state_nxt = (keep || regrant || sel_any) ? ST_OWNED : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    if (keep) begin
      hold_nxt = hold_cnt + HOLD_W'(1);
    end else if (regrant) begin
      hold_nxt = '0;
      ptr_nxt  = wrap_inc(grant_idx);
    end else if (sel_any) begin
      grant_nxt = sel_onehot;
      idx_nxt   = sel_idx;
      ptr_nxt   = wrap_inc(sel_idx);
      hold_nxt  = '0;
    end else begin
      grant_nxt = '0;
      hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      grant       <= grant_nxt;
      grant_valid <= |grant_nxt;
      grant_idx   <= idx_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  a_no_x_inputs: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({req, lock}));
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit         rst;
    logic       mode;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic [1:0] idx;
    int         tid;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  rr_lock_arbiter #(.INPUTS(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic m, input logic [3:0] rq, input logic [3:0] lk,
                     input logic [3:0] g, input logic [1:0] ix, input int t);
    vec_t v;
    v.rst = r; v.mode = m; v.req = rq; v.lock = lk; v.grant = g; v.idx = ix; v.tid = t;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    #2 rst_n = 1'b1;
  endtask

  // Drive one vector, queue its expectation, compare after the sampling edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    mode = v.mode; req = v.req; lock = v.lock;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_grant"}, 32'(grant), 32'(e.grant));
    chk({tag, "_idx"},   32'(grant_idx), 32'(e.idx));
    chk({tag, "_valid"}, 32'(grant_valid), 32'(|e.grant));
  endtask

  initial begin
    // fixed priority, held while req constant
    add(1, 0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 2);
    add(0, 0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 2);
    add(0, 0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 2);
    add(0, 0, 4'b1100, 4'b0000, 4'b0100, 2'd2, 2);
    add(0, 0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 2);
    add(0, 0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 2);
    // round-robin rotation
    add(1, 1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 3);
    add(0, 1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 3);
    add(0, 1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 3);
    add(0, 1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 3);
    add(0, 1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 3);
    // lock timeout at MAX_HOLD=4
    add(1, 1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 4);
    add(0, 1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 4);
    add(0, 1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 4);
    add(0, 1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 4);
    add(0, 1, 4'b0011, 4'b0001, 4'b0010, 2'd1, 4);
    add(0, 1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 4);
    // release to idle, index retained, then RR re-grant
    add(1, 1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 6);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 6);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 6);
    add(0, 1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 6);
    // mode change does not break lock; applies at next arbitration
    add(1, 1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 7);
    add(0, 0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 7);
    add(0, 1, 4'b0011, 4'b0000, 4'b0010, 2'd1, 7);
    add(0, 0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 7);
    // lock without matching req / for non-owner is ignored
    add(1, 0, 4'b0010, 4'b0001, 4'b0010, 2'd1, 8);
    add(0, 0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8);
    add(0, 0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 8);
    add(0, 0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 8);

    // reset state
    #3 rst_n = 1'b0;
    #4;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_valid", 32'(grant_valid), 32'h0);
    chk("reset_idx", 32'(grant_idx), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      apply(vecs[i], $sformatf("t%0d_v%0d", vecs[i].tid, i));
    end

    // sole locker: re-granted on timeout, hold counter wraps 0..3
    do_reset();
    for (int k = 0; k < 10; k++) begin
      vec_t v;
      v.rst = 0; v.mode = 1; v.req = 4'b0001; v.lock = 4'b0001;
      v.grant = 4'b0001; v.idx = 2'd0; v.tid = 5;
      apply(v, $sformatf("t5_k%0d", k));
      chk($sformatf("t5_hold_k%0d", k), 32'(dut.hold_cnt), 32'(k % 4));
    end

    // async reset mid-grant with no clock edge
    do_reset();
    begin
      vec_t v;
      v.rst = 0; v.mode = 1; v.req = 4'b0100; v.lock = 4'b0100;
      v.grant = 4'b0100; v.idx = 2'd2; v.tid = 1;
      apply(v, "t1_pre");
    end
    rst_n = 1'b0;
    #1;
    chk("t1_async_grant", 32'(grant), 32'h0);
    chk("t1_async_valid", 32'(grant_valid), 32'h0);
    chk("t1_async_idx", 32'(grant_idx), 32'h0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

endmodule
